crossbar_4x4_scheduler: RTL and testbench
=========================================

Name: crossbar_4x4_scheduler

Overview:
Sequencing and arbitration front-end for the 4x4 4-bit crossbar datapath. Four input requesters each present a 4-bit word and a 2-bit destination. The block arbitrates round-robin per output port, registers the winning words into per-output holding stages, and drives valid/ready handshakes on both sides. It sits between the input sources and the crossbar outputs.

Parameters:
DW, 4, data width per port
NP, 4, number of ports (fixed at 4; not to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  bit i: input i presents a word
req_dest  input  8  [2i+1:2i]: destination output of input i
req_data  input  16  [4i+3:4i]: data of input i
req_ready  output  4  bit i: input i's word is accepted this cycle (combinational)
out_valid  output  4  bit k: output k holds a valid word
out_data  output  16  [4k+3:4k]: word held at output k
out_src  output  8  [2k+1:2k]: input index that produced out_data k
out_ready  input  4  bit k: consumer takes output k's word this cycle

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, all RR pointers=0. req_ready=0 while in reset.
- Output stage k can accept when free_k = !out_valid[k] | out_ready[k].
- Per output k: candidates = {i : req_valid[i] & req_dest_i==k}. If free_k and there is at least one candidate, grant the first candidate at or after ptr_k, scanning ptr_k, ptr_k+1, ... mod 4.
- Each input targets exactly one output, so it receives at most one grant per cycle. req_ready[i] = granted. Acceptance = req_valid & req_ready.
- Latency: a word accepted in cycle n appears on out_data/out_valid in cycle n+1 (one register).
- On grant to i at output k: next cycle out_data_k=req_data_i, out_src_k=i, out_valid[k]=1, ptr_k=(i+1) mod 4.
- No grant but out_ready[k]&out_valid[k]: out_valid[k]=0 next cycle. Data and src hold their last values.
- Simultaneous drain and refill: the word is replaced with no bubble, so full throughput is 1 word/cycle/output.
- Stall (out_valid[k]=1, out_ready[k]=0): no grant at output k. Requesters for k see req_ready=0 and must hold valid, dest and data stable.
- Pointer moves only on a grant. An idle output keeps its pointer.
- A requester waits at most 3 grants at its output before it is served (no starvation).
- req_dest changing while req_valid=1 and not accepted: this is a protocol violation. Behaviour is defined only as "arbitrate on current values".
- rst_n asserted mid-transfer: all held words are dropped immediately. No partial state survives.

Optional Feature:
Macro XBAR_STATS_EN.
- Defined: adds output grant_cnt, 32 bits, with [8k+7:8k] = 8-bit saturating count of grants at output k. Count resets to 0, saturates at 255, and increments in the same cycle as the grant.
- Undefined: port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header xbar_pkg: NP=4, DW=4, PTR_W=2, port-slice index macros.
- One sub-module rr_arbiter_4: inputs req[3:0], ptr[1:0], en; outputs gnt[3:0] (one-hot or zero).
- The top instantiates it 4 times (one per output) and holds the pointers, output registers and the optional counters.

Test Plan:
- Reset: drive req_valid=4'b1111 during rst_n=0 -> out_valid=0, req_ready=0. After release, all pointers=0.
- Conflict: inputs 0,1,2,3 all dest=2, data 1,3,5,7, out_ready=1 held -> out 2 emits 1,3,5,7 on consecutive cycles with out_src 0,1,2,3. req_ready is one-hot rotating.
- Permutation: dest = 3,2,1,0 for inputs 0..3, data 4'hA,B,C,D -> next cycle out_valid=4'b1111, out_data = {A,B,C,D} on outputs {3,2,1,0}, all req_ready=1.
- Backpressure: out_ready[1]=0 with out_valid[1]=1 and input 2 requesting dest 1 -> req_ready[2]=0 and out_data_1 stable. Raising out_ready[1] -> accept that cycle, new word next cycle.
- Pointer fairness: ptr_0=2 (after granting input 1), inputs 0 and 3 both request output 0 -> input 3 is granted first, then input 0.
- Stats (XBAR_STATS_EN): 300 back-to-back grants at output 0 -> grant_cnt[7:0]=255, other fields 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared sizes and helpers for the 4x4 crossbar scheduler.
package xbar_pkg;
    localparam int NP    = 4;
    localparam int DW    = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 8;

    function automatic logic [PTR_W-1:0] oh2idx(input logic [NP-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NP; i++)
            if (oh[i]) oh2idx = PTR_W'(i);
    endfunction
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: grants the first requester at or after ptr, wrapping mod 4; zero grant when disabled.
module rr_arbiter_4
    import xbar_pkg::*;
(
    input  logic [NP-1:0]    req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NP-1:0]    gnt
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int o = 0; o < NP; o++) begin
            idx = ptr + PTR_W'(o);
            if (en && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/crossbar_4x4_scheduler.sv
// crossbar_4x4_scheduler: per-output round-robin arbitration into one-deep holding registers.
// Define XBAR_STATS_EN to add per-output 8-bit saturating grant counters on grant_cnt.
module crossbar_4x4_scheduler
    import xbar_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NP-1:0]       req_valid,
    input  logic [NP*PTR_W-1:0] req_dest,
    input  logic [NP*DW-1:0]    req_data,
    output logic [NP-1:0]       req_ready,
    output logic [NP-1:0]       out_valid,
    output logic [NP*DW-1:0]    out_data,
    output logic [NP*PTR_W-1:0] out_src,
    input  logic [NP-1:0]       out_ready
`ifdef XBAR_STATS_EN
    ,
    output logic [NP*CNT_W-1:0] grant_cnt
`endif
);
    logic [NP-1:0][NP-1:0]    cand, gnt;
    logic [NP-1:0]            free;
    logic [NP-1:0]            valid_q, valid_d;
    logic [NP-1:0][DW-1:0]    data_q, data_d;
    logic [NP-1:0][PTR_W-1:0] src_q, src_d, ptr_q, ptr_d;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    always_comb begin
        cand = '0;
        free = '0;
        for (int k = 0; k < NP; k++) begin
            free[k] = rst_n && (!valid_q[k] || out_ready[k]);
            for (int i = 0; i < NP; i++)
                cand[k][i] = req_valid[i] && req_dest[i*PTR_W +: PTR_W] == PTR_W'(k);
        end
    end

    for (genvar k = 0; k < NP; k++) begin : g_arb
        rr_arbiter_4 u_arb (
            .req (cand[k]),
            .ptr (ptr_q[k]),
            .en  (free[k]),
            .gnt (gnt[k])
        );
    end

    always_comb begin
        req_ready = '0;
        valid_d   = valid_q;
        data_d    = data_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        for (int k = 0; k < NP; k++) begin
            req_ready = req_ready | gnt[k];
            if (gnt[k] != '0) begin
                valid_d[k] = 1'b1;
                src_d[k]   = oh2idx(gnt[k]);
                data_d[k]  = req_data[DW*src_d[k] +: DW];
                ptr_d[k]   = src_d[k] + PTR_W'(1);
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

`ifdef XBAR_STATS_EN
    logic [NP-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NP; k++)
            if (gnt[k] != '0 && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_crossbar_4x4_scheduler.sv
// tb_crossbar_4x4_scheduler: directed and randomized checks against a behavioural scheduler model.
module tb_crossbar_4x4_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_dest = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [3:0]  out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_src;
    logic [3:0]  out_ready = '0;
`ifdef XBAR_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: per-output pointer, holding word and grant count.
    int         m_ptr[4];
    bit         m_val[4];
    logic [3:0] m_dat[4];
    logic [1:0] m_src[4];
    int         m_cnt[4];
    logic [3:0] last_rdy;

    crossbar_4x4_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef XBAR_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ptr[k] = 0;
            m_val[k] = 0;
            m_dat[k] = '0;
            m_src[k] = '0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_dest  = '0;
        out_ready = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        model_reset();
        @(negedge clk);
        check("rst_hold_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    // One cycle: check held outputs, apply inputs, check req_ready, advance the model.
    task automatic step(input logic [3:0] v, input logic [7:0] d, input logic [15:0] dat, input logic [3:0] r);
        logic [3:0]  ev, exp_rdy;
        logic [15:0] ed;
        logic [7:0]  es;
        logic [31:0] ec;
        bit          done;
        int          i;
        @(negedge clk);
        ev = '0; ed = '0; es = '0; ec = '0;
        for (int k = 0; k < 4; k++) begin
            ev[k]         = m_val[k];
            ed[4*k +: 4]  = m_dat[k];
            es[2*k +: 2]  = m_src[k];
            ec[8*k +: 8]  = 8'(m_cnt[k]);
        end
        check("out_valid", 32'(out_valid), 32'(ev));
        check("out_data", 32'(out_data), 32'(ed));
        check("out_src", 32'(out_src), 32'(es));
`ifdef XBAR_STATS_EN
        check("grant_cnt", grant_cnt, ec);
`endif
        req_valid = v;
        req_dest  = d;
        req_data  = dat;
        out_ready = r;
        #1;
        exp_rdy = '0;
        for (int k = 0; k < 4; k++) begin
            done = 0;
            if (!m_val[k] || r[k]) begin
                for (int j = 0; j < 4; j++) begin
                    i = (m_ptr[k] + j) % 4;
                    if (!done && v[i] && int'(d[2*i +: 2]) == k) begin
                        done       = 1;
                        exp_rdy[i] = 1'b1;
                        m_val[k]   = 1;
                        m_dat[k]   = dat[4*i +: 4];
                        m_src[k]   = 2'(i);
                        m_ptr[k]   = (i + 1) % 4;
                        if (m_cnt[k] < 255) m_cnt[k]++;
                    end
                end
            end
            if (!done && r[k]) m_val[k] = 0;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_rdy = exp_rdy;
    endtask

    logic [3:0]  cv;
    logic [7:0]  cd;
    logic [15:0] cdat;

    initial begin
        model_reset();
        do_reset();

        // Four-way conflict on output 2: rotating one-hot ready, words 1,3,5,7.
        cv = 4'hF;
        for (int n = 0; n < 4; n++) begin
            step(cv, 8'hAA, 16'h7531, 4'hF);
            check("conflict_rdy", 32'(req_ready), 32'(1 << n));
            cv = cv & ~last_rdy;
        end
        step(4'h0, 8'h00, 16'h0000, 4'hF);
        check("conflict_last_src", 32'(out_src[5:4]), 32'd3);
        check("conflict_last_data", 32'(out_data[11:8]), 32'h7);

        // Permutation: every input reaches a distinct output in one cycle.
        step(4'hF, 8'h1B, 16'hDCBA, 4'hF);
        check("perm_rdy", 32'(req_ready), 32'hF);
        step(4'h0, 8'h00, 16'h0000, 4'h0);
        check("perm_valid", 32'(out_valid), 32'hF);
        check("perm_data", 32'(out_data), 32'hABCD);

        // Backpressure on output 1 with input 2 waiting.
        step(4'h0, 8'h00, 16'h0000, 4'hF);
        step(4'h4, 8'h10, 16'h0900, 4'h0);
        step(4'h4, 8'h10, 16'h0600, 4'h0);
        check("bp_stall_rdy", 32'(req_ready), 32'h0);
        step(4'h4, 8'h10, 16'h0600, 4'h0);
        check("bp_stable_data", 32'(out_data[7:4]), 32'h9);
        step(4'h4, 8'h10, 16'h0600, 4'h2);
        check("bp_release_rdy", 32'(req_ready), 32'h4);
        step(4'h0, 8'h00, 16'h0000, 4'h0);
        check("bp_new_data", 32'(out_data[7:4]), 32'h6);

        // Fairness on output 0 after input 1 moved the pointer to 2.
        do_reset();
        step(4'h2, 8'h00, 16'h0050, 4'hF);
        step(4'h9, 8'h00, 16'h3001, 4'hF);
        check("fair_first", 32'(req_ready), 32'h8);
        step(4'h1, 8'h00, 16'h3001, 4'hF);
        check("fair_second", 32'(req_ready), 32'h1);

        // Random traffic honouring the hold-until-accepted rule.
        cv = '0; cd = '0; cdat = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!cv[i]) begin
                    cv[i]         = ($urandom_range(0, 9) < 7);
                    cd[2*i +: 2]  = 2'($urandom_range(0, 3));
                    cdat[4*i +: 4] = 4'($urandom_range(0, 15));
                end
            end
            step(cv, cd, cdat, 4'($urandom) | 4'($urandom));
            cv = cv & ~last_rdy;
        end
        do_reset();
        step(4'h0, 8'h00, 16'h0000, 4'h0);

`ifdef XBAR_STATS_EN
        for (int n = 0; n < 300; n++) step(4'h1, 8'h00, 16'(n % 16), 4'hF);
        step(4'h0, 8'h00, 16'h0000, 4'hF);
        check("stats_sat", grant_cnt, 32'h0000_00FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
